inst_mem_resp: RTL and testbench
================================

// Module: inst_mem_resp
// PURPOSE
//  Instruction-memory responder on the fetch interface driven by the PC.
//  - Receives I_inst_addr, returns the instruction word after a fixed number of wait states.
//  - Drives O_stall back to the PC so the PC holds its address until the word is delivered.
//  - Side write port preloads or patches program memory, from the bench or a loader.
// PARAMETERS
//  ADDR_W       8   instruction address width; word-addressed
//  DATA_W       32  instruction word width
//  DEPTH        256 number of words; must equal 2**ADDR_W
//  WAIT_STATES  2   stall cycles per fetch; legal range 1..15
// PORTS
//  clk          in  1       single clock, rising edge
//  rst          in  1       synchronous, active-low reset
//  I_inst_addr  in  ADDR_W  fetch address from PC
//  I_wr_en      in  1       write strobe for program memory
//  I_wr_addr    in  ADDR_W  write address
//  I_wr_data    in  DATA_W  write data
//  I_wr_par_inv in  1       test hook: store inverted parity; used only with IMEM_PARITY_EN
//  O_inst       out DATA_W  fetched instruction
//  O_inst_valid out 1       O_inst is valid this cycle (1-cycle pulse)
//  O_stall      out 1       to PC STALL input: hold the address
//  O_par_err    out 1       parity error on the delivered word
// BEHAVIOUR
//  - Reset (rst==0 at posedge):
//    - State=WAIT, cnt=WAIT_STATES.
//    - O_inst=0, O_inst_valid=0, O_stall=1, O_par_err=0.
//    - Memory contents are not reset.
//  - FSM, 2 states:
//    - WAIT: O_stall=1, O_inst_valid=0.
//      - cnt>1: cnt decrements.
//      - cnt==1: mem[I_inst_addr] is registered into O_inst; go to RESP.
//    - RESP: O_stall=0, O_inst_valid=1, O_inst held.
//      - The PC advances at this edge.
//      - Always return to WAIT with cnt=WAIT_STATES.
//      - No address-change detection, so a branch to the same address still refetches.
//  - Timing: fetch latency WAIT_STATES+1 cycles from address stable to valid.
//    - Throughput: 1 word per WAIT_STATES+1 cycles.
//  - Address is sampled only in the final WAIT cycle. It is stable there because O_stall=1.
//  - Writes: mem[I_wr_addr]<=I_wr_data at posedge when I_wr_en=1, in any state, including RESP.
//  - Write-first collision: write in the sampling cycle with I_wr_addr==I_inst_addr.
//    - O_inst gets I_wr_data, not the stale word.
//  - Reset mid-fetch:
//    - Abandons the fetch; no valid pulse for it.
//    - After rst returns to 1, a full WAIT_STATES count restarts.
//  - O_inst keeps its last value outside RESP.
//    - Consumers must qualify it with O_inst_valid.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//    - Each word stores an extra bit, ^I_wr_data XOR I_wr_par_inv, computed at write.
//    - On the registered read, recompute parity. On mismatch, in the RESP cycle:
//      - O_par_err=1.
//      - O_inst=0 (NOP).
//      - O_inst_valid still 1.
//    - The parity bit follows the write-first rule.
//  IMEM_PARITY_EN undefined:
//    - No parity storage; O_par_err tied 0; I_wr_par_inv ignored.
// TESTING
//  1. Reset:
//     - rst=0 for 3 cycles -> O_stall=1, O_inst_valid=0, O_inst=0 each cycle.
//     - Release -> first O_inst_valid at cycle 3 (WAIT_STATES=2).
//  2. Sequential fetch:
//     - Preload mem[0..3]=32'h11,22,33,44.
//     - Bench PC increments on !O_stall.
//     - Valid pulses every 3rd cycle with 11,22,33,44 in order.
//     - O_stall low only on valid cycles.
//  3. Branch to self:
//     - Hold I_inst_addr=5, mem[5]=32'hDEAD_BEEF.
//     - Repeated valid pulses every 3 cycles, each with DEAD_BEEF.
//  4. Write collision:
//     - Write mem[7]=32'hCAFE in the sampling cycle of fetch addr 7 (old value 32'h0BAD).
//     - Next cycle O_inst=32'hCAFE with valid=1.
//  5. Reset mid-fetch:
//     - Assert rst=0 one cycle after WAIT entry; release.
//     - No valid pulse for the aborted fetch.
//     - Next valid exactly WAIT_STATES+1 cycles after release.
//  6. Parity (IMEM_PARITY_EN):
//     - Write mem[9]=32'h1 with I_wr_par_inv=1; fetch 9.
//     - O_par_err=1, O_inst=0, valid=1.
//     - Rewrite with inv=0 -> O_par_err=0, O_inst=32'h1.

Source files
------------

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: returns mem[I_inst_addr] after WAIT_STATES stall cycles.
// Optional per-word parity checking is enabled by defining IMEM_PARITY_EN.
module inst_mem_resp #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] I_inst_addr,
    input  logic              I_wr_en,
    input  logic [ADDR_W-1:0] I_wr_addr,
    input  logic [DATA_W-1:0] I_wr_data,
    input  logic              I_wr_par_inv,
    output logic [DATA_W-1:0] O_inst,
    output logic              O_inst_valid,
    output logic              O_stall,
    output logic              O_par_err
);

    typedef enum logic [0:0] {StWait, StResp} state_e;

    localparam logic [3:0] CntInit = 4'(WAIT_STATES);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] inst_q;
    logic              valid_q;
    logic              stall_q;
    logic              par_err_q;

    logic              wr_hit;
    logic [DATA_W-1:0] rd_data_d;
    logic              fetch_err_d;

    // A write to the address being fetched bypasses the array (write-first).
    assign wr_hit    = I_wr_en && (I_wr_addr == I_inst_addr);
    assign rd_data_d = wr_hit ? I_wr_data : mem_q[I_inst_addr];

    always_ff @(posedge clk) begin
        if (I_wr_en) begin
            mem_q[I_wr_addr] <= I_wr_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_q [DEPTH];
    logic wr_par;
    logic rd_par_d;

    assign wr_par      = (^I_wr_data) ^ I_wr_par_inv;
    assign rd_par_d    = wr_hit ? wr_par : par_q[I_inst_addr];
    assign fetch_err_d = (^rd_data_d) != rd_par_d;

    always_ff @(posedge clk) begin
        if (I_wr_en) begin
            par_q[I_wr_addr] <= wr_par;
        end
    end
`else
    logic unused_par_inv;
    assign unused_par_inv = I_wr_par_inv;
    assign fetch_err_d    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StWait;
            cnt_q     <= CntInit;
            inst_q    <= '0;
            valid_q   <= 1'b0;
            stall_q   <= 1'b1;
            par_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StWait: begin
                    if (cnt_q > 4'd1) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // A corrupted word is delivered as a NOP (all zeros).
                        inst_q    <= fetch_err_d ? '0 : rd_data_d;
                        par_err_q <= fetch_err_d;
                        valid_q   <= 1'b1;
                        stall_q   <= 1'b0;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    state_q   <= StWait;
                    cnt_q     <= CntInit;
                    valid_q   <= 1'b0;
                    stall_q   <= 1'b1;
                    par_err_q <= 1'b0;
                end
                default: begin
                    state_q <= StWait;
                    cnt_q   <= CntInit;
                end
            endcase
        end
    end

    assign O_inst       = inst_q;
    assign O_inst_valid = valid_q;
    assign O_stall      = stall_q;
    assign O_par_err    = par_err_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp: driver pushes per-cycle and per-fetch expectations,
// an independent monitor pops and compares them against the DUT outputs.
module tb_inst_mem_resp;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic [7:0]  I_inst_addr;
    logic        I_wr_en;
    logic [7:0]  I_wr_addr;
    logic [31:0] I_wr_data;
    logic        I_wr_par_inv;
    logic [31:0] O_inst;
    logic        O_inst_valid;
    logic        O_stall;
    logic        O_par_err;

    inst_mem_resp #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .DEPTH       (256),
        .WAIT_STATES (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .I_inst_addr  (I_inst_addr),
        .I_wr_en      (I_wr_en),
        .I_wr_addr    (I_wr_addr),
        .I_wr_data    (I_wr_data),
        .I_wr_par_inv (I_wr_par_inv),
        .O_inst       (O_inst),
        .O_inst_valid (O_inst_valid),
        .O_stall      (O_stall),
        .O_par_err    (O_par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic rst;
        logic vld;
    } cyc_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    cyc_t        cyc_q[$];
    exp_t        data_q[$];
    logic [31:0] ref_mem [256];
    logic        ref_inv [256];

    int   checks = 0;
    int   errors = 0;
    int   n = 0;          // clock edges since reset release
    bit   prev_sample = 0;
    bit   mon_en = 0;
    logic [7:0]  pc;
    logic [31:0] last_inst = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one clock cycle of stimulus and record what the spec says must follow.
    task automatic drive(input logic rst_v, input logic [7:0] addr, input logic we,
                         input logic [7:0] wa, input logic [31:0] wd, input logic inv);
        cyc_t        c;
        exp_t        e;
        logic [31:0] word;
        logic        bad;
        rst          = rst_v;
        I_inst_addr  = addr;
        I_wr_en      = we;
        I_wr_addr    = wa;
        I_wr_data    = wd;
        I_wr_par_inv = inv;
        c.rst = !rst_v;
        c.vld = 1'b0;
        if (!rst_v) begin
            n           = 0;
            prev_sample = 0;
        end else begin
            n++;
            prev_sample = ((n % (W + 1)) == W);
            if (prev_sample) begin
                word = (we && wa == addr) ? wd  : ref_mem[addr];
                bad  = (we && wa == addr) ? inv : ref_inv[addr];
`ifndef IMEM_PARITY_EN
                bad = 1'b0;
`endif
                e.err  = bad;
                e.data = bad ? 32'h0 : word;
                data_q.push_back(e);
                c.vld = 1'b1;
            end
        end
        cyc_q.push_back(c);
        if (we) begin
            ref_mem[wa] = wd;
            ref_inv[wa] = inv;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [7:0] addr);
        drive(1'b1, addr, 1'b0, 8'h0, 32'h0, 1'b0);
    endtask

    task automatic run_pc(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (prev_sample) pc = pc + 8'd1;
            idle(pc);
        end
    endtask

    always @(posedge clk) begin
        cyc_t c;
        exp_t e;
        #1;
        if (mon_en) begin
            if (cyc_q.size() == 0) begin
                check("cycle_queue_empty", 32'(cyc_q.size()), 32'd1);
            end else begin
                c = cyc_q.pop_front();
                check("valid", 32'(O_inst_valid), 32'(c.vld));
                check("stall", 32'(O_stall), 32'(!c.vld));
                if (c.rst) begin
                    check("reset_inst", O_inst, 32'h0);
                    check("reset_par_err", 32'(O_par_err), 32'h0);
                    last_inst = 32'h0;
                end else if (O_inst_valid) begin
                    if (data_q.size() == 0) begin
                        check("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = data_q.pop_front();
                        check("inst", O_inst, e.data);
                        check("par_err", 32'(O_par_err), 32'(e.err));
                        last_inst = e.data;
                    end
                end else begin
                    check("inst_hold", O_inst, last_inst);
                end
            end
        end
    end

    initial begin
        rst          = 1'b0;
        I_inst_addr  = '0;
        I_wr_en      = 1'b0;
        I_wr_addr    = '0;
        I_wr_data    = '0;
        I_wr_par_inv = 1'b0;
        pc           = '0;
        @(negedge clk);
        mon_en = 1;

        // Preload every word while held in reset, then fixed test words.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 8'h0, 1'b1, 8'(i), $urandom, 1'b0);
        end
        drive(1'b0, 8'h0, 1'b1, 8'd0, 32'h11, 1'b0);
        drive(1'b0, 8'h0, 1'b1, 8'd1, 32'h22, 1'b0);
        drive(1'b0, 8'h0, 1'b1, 8'd2, 32'h33, 1'b0);
        drive(1'b0, 8'h0, 1'b1, 8'd3, 32'h44, 1'b0);
        drive(1'b0, 8'h0, 1'b1, 8'd5, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, 8'h0, 1'b1, 8'd7, 32'h0BAD, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h0, 1'b0, 8'h0, 32'h0, 1'b0);

        // Sequential fetch: 11,22,33,44 at edges 2,5,8,11.
        pc = 8'd0;
        run_pc(12);

        // Branch to self.
        for (int i = 0; i < 9; i++) idle(8'd5);

        // Write collision in the sampling cycle.
        while (((n + 1) % (W + 1)) != W) idle(8'd7);
        drive(1'b1, 8'd7, 1'b1, 8'd7, 32'hCAFE, 1'b0);
        for (int i = 0; i < 3; i++) idle(8'd7);

        // Reset one cycle after entering WAIT.
        while (!prev_sample) idle(8'd5);
        idle(8'd5);
        drive(1'b0, 8'd5, 1'b0, 8'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) idle(8'd5);

        // Parity: inverted parity word, then a clean rewrite.
        drive(1'b1, 8'd9, 1'b1, 8'd9, 32'h1, 1'b1);
        for (int i = 0; i < 3; i++) idle(8'd9);
        drive(1'b1, 8'd9, 1'b1, 8'd9, 32'h1, 1'b0);
        for (int i = 0; i < 3; i++) idle(8'd9);

        // Random traffic with dense address collisions and sporadic resets.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) != 0), 8'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) idle(8'd0);

        check("leftover_fetches", 32'(data_q.size()), 32'd0);
        check("leftover_cycles", 32'(cyc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
